ow_ds18b20_responder: RTL



---
 rtl/ow_ds18b20_responder.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/ow_ds18b20_responder.sv
// One-wire responder that emulates a single DS18B20: reset/presence, Skip ROM,
// Convert T and Read Scratchpad, with the temperature supplied on temp_in.
module ow_ds18b20_responder #(
  parameter int unsigned CLK_FREQ     = 12000000,
  parameter int unsigned RESET_MIN_US = 480,
  parameter int unsigned PRES_WAIT_US = 30,
  parameter int unsigned PRES_LEN_US  = 120,
  parameter int unsigned SAMPLE_US    = 30,
  parameter int unsigned HOLD0_US     = 45,
  parameter int unsigned CONV_MS      = 750
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        ow_in,
  input  logic [15:0] temp_in,
  output logic        ow_pull_low,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        conv_busy,
  output logic        err_cmd
);
  localparam int unsigned US         = CLK_FREQ / 1000000;
  localparam int unsigned RESET_CYC  = RESET_MIN_US * US;
  localparam int unsigned PW_CYC     = PRES_WAIT_US * US;
  localparam int unsigned PL_CYC     = PRES_LEN_US * US;
  localparam int unsigned SAMPLE_CYC = SAMPLE_US * US;
  localparam int unsigned HOLD_CYC   = HOLD0_US * US;
  localparam int unsigned CONV_CYC   = CONV_MS * 1000 * US;
  localparam int unsigned LOW_W      = $clog2(RESET_CYC + 1) + 1;
  localparam int unsigned TMR_W      = $clog2(PW_CYC + PL_CYC + SAMPLE_CYC + HOLD_CYC + 1);
  localparam int unsigned CONV_W     = $clog2(CONV_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRES_WAIT,
    ST_PRES_DRIVE,
    ST_ROM_CMD,
    ST_FUNC_CMD,
    ST_TX_SCRATCH,
    ST_CONV_READ
  } state_t;

  state_t             state;
  logic               ow_s1, ow_s2, ow_prev;
  logic [LOW_W-1:0]   low_cnt;
  logic [TMR_W-1:0]   tmr;
  logic [TMR_W-1:0]   hold_cnt;
  logic               slot_act, hold_act;
  logic [6:0]         bit_cnt;
  logic [6:0]         rx_sh;
  logic [71:0]        tx_sh;
  logic [CONV_W-1:0]  conv_cnt;
  logic [15:0]        temp_q;

  logic               fall, rise, bus_rst;
  logic [7:0]         rx_byte;
  logic [63:0]        sp_body;

  // Maxim CRC-8 (reflected 0x31), bytes in order, each byte LSB first
  function automatic logic [7:0] crc8(input logic [63:0] data);
    logic [7:0] crc;
    logic       fb;
    crc = 8'h00;
    for (int i = 0; i < 64; i++) begin
      fb  = crc[0] ^ data[i];
      crc = {1'b0, crc[7:1]} ^ (fb ? 8'h8C : 8'h00);
    end
    return crc;
  endfunction

  assign fall    = ow_prev & ~ow_s2;
  assign rise    = ~ow_prev & ow_s2;
  assign bus_rst = rise && (low_cnt >= LOW_W'(RESET_CYC));
  assign rx_byte = {ow_s2, rx_sh};
  assign sp_body = {8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, temp_q};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ow_s1       <= 1'b1;
      ow_s2       <= 1'b1;
      ow_prev     <= 1'b1;
      low_cnt     <= '0;
      state       <= ST_IDLE;
      tmr         <= '0;
      hold_cnt    <= '0;
      slot_act    <= 1'b0;
      hold_act    <= 1'b0;
      bit_cnt     <= '0;
      rx_sh       <= '0;
      tx_sh       <= '1;
      conv_cnt    <= '0;
      temp_q      <= 16'h0550;
      ow_pull_low <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_byte    <= 8'h00;
      conv_busy   <= 1'b0;
      err_cmd     <= 1'b0;
    end else begin
      ow_s1     <= ow_in;
      ow_s2     <= ow_s1;
      ow_prev   <= ow_s2;
      cmd_valid <= 1'b0;
      err_cmd   <= 1'b0;

      if (!ow_s2) begin
        if (low_cnt != '1) low_cnt <= low_cnt + 1'b1;
      end else begin
        low_cnt <= '0;
      end

      // conversion runs independently of the bus state
      if (conv_busy) begin
        if (conv_cnt == CONV_W'(CONV_CYC - 1)) begin
          conv_busy <= 1'b0;
          temp_q    <= temp_in;
        end else begin
          conv_cnt <= conv_cnt + 1'b1;
        end
      end

      // read-0 hold window; may outlive the slot's state (last scratchpad bit)
      if (hold_act) begin
        if (hold_cnt == TMR_W'(HOLD_CYC - 1)) begin
          hold_act    <= 1'b0;
          ow_pull_low <= 1'b0;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end

      if (bus_rst) begin
        state       <= ST_PRES_WAIT;
        tmr         <= '0;
        slot_act    <= 1'b0;
        hold_act    <= 1'b0;
        ow_pull_low <= 1'b0;
        bit_cnt     <= '0;
      end else begin
        case (state)
          ST_PRES_WAIT: begin
            if (tmr == TMR_W'(PW_CYC - 1)) begin
              state       <= ST_PRES_DRIVE;
              tmr         <= '0;
              ow_pull_low <= 1'b1;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          ST_PRES_DRIVE: begin
            if (tmr == TMR_W'(PL_CYC - 1)) begin
              state       <= ST_ROM_CMD;
              tmr         <= '0;
              ow_pull_low <= 1'b0;
              bit_cnt     <= '0;
              slot_act    <= 1'b0;
            end else begin
              tmr <= tmr + 1'b1;
            end
          end
          ST_ROM_CMD, ST_FUNC_CMD: begin
            if (fall) begin
              slot_act <= 1'b1;
              tmr      <= '0;
            end else if (slot_act) begin
              if (tmr == TMR_W'(SAMPLE_CYC - 1)) begin
                slot_act <= 1'b0;
                rx_sh    <= rx_byte[7:1];
                if (bit_cnt == 7'd7) begin
                  bit_cnt   <= '0;
                  cmd_byte  <= rx_byte;
                  cmd_valid <= 1'b1;
                  if (state == ST_ROM_CMD) begin
                    if (rx_byte == 8'hCC) begin
                      state <= ST_FUNC_CMD;
                    end else begin
                      err_cmd <= 1'b1;
                      state   <= ST_IDLE;
                    end
                  end else if (rx_byte == 8'h44) begin
                    conv_busy <= 1'b1;
                    conv_cnt  <= '0;
                    state     <= ST_CONV_READ;
                  end else if (rx_byte == 8'hBE) begin
                    tx_sh <= {crc8(sp_body), sp_body};
                    state <= ST_TX_SCRATCH;
                  end else begin
                    err_cmd <= 1'b1;
                    state   <= ST_IDLE;
                  end
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                end
              end else begin
                tmr <= tmr + 1'b1;
              end
            end
          end
          ST_TX_SCRATCH: begin
            if (fall) begin
              if (!tx_sh[0]) begin
                ow_pull_low <= 1'b1;
                hold_act    <= 1'b1;
                hold_cnt    <= '0;
              end
              tx_sh <= {1'b1, tx_sh[71:1]};
              if (bit_cnt == 7'd71) begin
                bit_cnt <= '0;
                state   <= ST_IDLE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ST_CONV_READ: begin
            if (fall && conv_busy) begin
              ow_pull_low <= 1'b1;
              hold_act    <= 1'b1;
              hold_cnt    <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
